dma_top_sim: RTL and testbench
==============================

// Module: dma_top_sim
// PURPOSE
//  Single-clock simulation top of the reference DMA NIC datapath. Forwards AXI-Stream packets host(DMA)->QSFP0
//  and QSFP0->host through per-direction sync FIFOs. Rewrites the NetFPGA tuser port fields on both paths.
//  Sits where the PCIe/DMA core and QSFP0 MAC meet the datapath; the bench drives both AXIS sides directly.
// PARAMETERS
//  C_DATA_WIDTH       512                  AXIS tdata width, both ports
//  KEEP_WIDTH         C_DATA_WIDTH/32      tkeep width, one bit per 32-bit dword
//  C_USER_WIDTH       128                  tuser width; [15:0] len, [23:16] src_port, [31:24] dst_port
//  FIFO_DEPTH         16                   beats per direction FIFO, power of 2, >=4
//  RESET_HOLD_CYCLES  16                   cycles after reset release before init_done rises
// PORTS
//  sys_clk            in   1     single clock; all logic on rising edge
//  sys_reset          in   1     reset; synchronous, active-high
//  s_axis_dma_tdata/tkeep/tuser/tvalid/tlast in  C_DATA_WIDTH/KEEP_WIDTH/C_USER_WIDTH/1/1  host->card stream
//  s_axis_dma_tready  out  1
//  m_axis_qsfp0_tdata/tkeep/tuser/tvalid/tlast out  same widths   card->wire stream
//  m_axis_qsfp0_tready in  1
//  s_axis_qsfp0_tdata/tkeep/tuser/tvalid/tlast in   same widths   wire->card stream
//  s_axis_qsfp0_tready out 1
//  m_axis_dma_tdata/tkeep/tuser/tvalid/tlast out    same widths   card->host stream
//  m_axis_dma_tready  in   1
//  init_done          out  1     datapath ready after reset hold
// BEHAVIOUR
//  - Reset: all tvalid=0, all s_*_tready=0, init_done=0, FIFOs empty, hold counter=0.
//  - Hold counter counts cycles with sys_reset low; init_done=1 once count==RESET_HOLD_CYCLES, then stays 1.
//  - s_*_tready = init_done & !fifo_full. Beat accepted when tvalid&tready; stored as {tdata,tkeep,tuser',tlast}.
//  - Full: tready=0 even if a pop occurs the same cycle (no pass-through when full). Simultaneous push+pop
//    when not full/not empty: occupancy unchanged.
//  - Empty: m_*_tvalid=0. Latency: a beat accepted in cycle N is presented at m_* in cycle N+1 at the earliest.
//  - m_* holds data/valid stable until m_*_tready; pop on tvalid&tready. No drop, no reorder, packets not interleaved.
//  - tuser' rewrite: DMA->QSFP0: src_port=8'h02, dst_port=8'h01. QSFP0->DMA: src_port=8'h01, dst_port=8'h02.
//    len[15:0] and bits [127:32] pass unchanged. tuser rewritten on every beat.
//  - tdata/tkeep/tlast pass bit-exact; tkeep is not checked or modified.
//  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH. full = MSBs differ, low bits equal.
//  - Reset mid-packet: FIFOs flushed, partial packet discarded, outputs drop tvalid on the next edge.
// CONFIGURATION
//  - Macro DMA_TOP_SIM_PKT_COUNTERS_EN defined: adds outputs pkt_cnt_to_qsfp0[31:0], pkt_cnt_to_dma[31:0].
//    Each increments by 1 on a tlast handshake at its m_* port and wraps 32'hFFFF_FFFF->0.
//    Reset to 0; not affected by tready stalls.
//  - Macro undefined: these ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  - Package dma_top_sim_pkg: port codes PORT_NF0=8'h01, PORT_DMA0=8'h02.
//    tuser field offsets LEN_LSB=0, SRC_LSB=16, DST_LSB=24; beat struct typedef {data,keep,user,last}.
//  - Sub-module axis_sync_fifo (instantiated twice, one per direction).
//    Parameterised by width and depth; registered output stage.
//  - Top level holds the hold counter, the tuser rewrite, and the optional counters.
// TESTING
//  1 Reset 20 cycles, release: init_done=0 and tready=0 for 16 cycles, then init_done=1, both tready=1.
//  2 Single beat DMA in: tdata=512'hA5..A5, tkeep=16'hFFFF, tlast=1, tuser[15:0]=64.
//    QSFP0 out next cycle: same data, tuser[23:16]=02, [31:24]=01, len=64.
//  3 4-beat packet QSFP0 in, m_axis_dma_tready toggled 50%: 4 beats out in order.
//    src=01, dst=02; tlast only on beat 4.
//  4 m_axis_qsfp0_tready=0, push 16 beats: s_axis_dma_tready=0 after the 16th.
//    Raise tready: 16 beats drain in order, then tready=1.
//  5 Both directions full-rate concurrently for 100 packets: no loss, no cross-contamination.
//    With DMA_TOP_SIM_PKT_COUNTERS_EN, both counters=100.
//  6 Assert sys_reset mid-packet: next edge all tvalid=0, FIFOs empty, init_done=0.
//    After release and hold, a fresh packet passes intact.

Source files
------------

// File: rtl/dma_top_sim_pkg.sv
// dma_top_sim_pkg -- shared constants and types for the DMA NIC sim datapath.
//   PORT_NF0 / PORT_DMA0 : NetFPGA one-hot port codes written into tuser
//   LEN_LSB / SRC_LSB / DST_LSB : tuser field offsets (len 16b, src 8b, dst 8b)
//   beat_t : one AXIS beat {data, keep, user, last} at the default widths
package dma_top_sim_pkg;

  localparam int DATA_W = 512;
  localparam int KEEP_W = DATA_W / 32;
  localparam int USER_W = 128;

  localparam logic [7:0] PORT_NF0  = 8'h01;
  localparam logic [7:0] PORT_DMA0 = 8'h02;

  localparam int LEN_LSB = 0;
  localparam int SRC_LSB = 16;
  localparam int DST_LSB = 24;

  // Field order matches the packing used inside the direction FIFOs.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic [USER_W-1:0] user;
    logic              last;
  } beat_t;

endpackage

// File: rtl/dma_top_sim_if.sv
// dma_top_sim_if -- AXI-Stream bundle.
//   tdata/tkeep/tuser/tvalid/tlast : source -> sink
//   tready                         : sink -> source
//   modport master : drives a stream out; modport slave : accepts a stream in
interface dma_top_sim_if #(
  parameter int DW = 512,
  parameter int KW = DW / 32,
  parameter int UW = 128
);
  logic [DW-1:0] tdata;
  logic [KW-1:0] tkeep;
  logic [UW-1:0] tuser;
  logic          tvalid;
  logic          tlast;
  logic          tready;

  modport master (output tdata, tkeep, tuser, tvalid, tlast, input  tready);
  modport slave  (input  tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/dma_top_sim_axis_sync_fifo.sv
// axis_sync_fifo -- single-clock beat FIFO used once per datapath direction.
//   clk_i, rst_i     : clock, synchronous active-high reset (flushes pointers)
//   en_i             : write enable gate; wr_ready_o is held low while en_i=0
//   wr_data_i/wr_valid_i/wr_ready_o : push side, beat taken on valid&ready
//   rd_data_o/rd_valid_o/rd_ready_i : pop side, beat leaves on valid&ready
// Read data comes straight from the storage flops, so a beat written on
// edge N is visible from cycle N+1 and never bypasses the array.
module axis_sync_fifo #(
  parameter int WIDTH = 657,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             rd_valid_o,
  input  logic             rd_ready_i
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             full, empty, push, pop;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  // Full blocks writes even when a pop happens in the same cycle; this keeps
  // wr_ready_o a pure function of registered state.
  assign wr_ready_o = en_i & ~full;
  assign rd_valid_o = ~empty;
  assign push       = wr_valid_i & wr_ready_o;
  assign pop        = rd_valid_o & rd_ready_i;
  assign rd_data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: nothing is read until the pointers say so.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end
endmodule

// File: rtl/dma_top_sim.sv
// dma_top_sim -- single-clock sim top of the reference DMA NIC datapath.
// Forwards host(DMA)->QSFP0 and QSFP0->host through one FIFO per direction
// and rewrites the tuser src/dst port fields on every beat.
//   sys_clk, sys_reset : clock, synchronous active-high reset
//   s_axis_dma   (slave)  : host -> card stream
//   m_axis_qsfp0 (master) : card -> wire stream
//   s_axis_qsfp0 (slave)  : wire -> card stream
//   m_axis_dma   (master) : card -> host stream
//   init_done            : high once RESET_HOLD_CYCLES cycles have passed out of reset
// Optional macro DMA_TOP_SIM_PKT_COUNTERS_EN adds pkt_cnt_to_qsfp0 and
// pkt_cnt_to_dma: free-running 32-bit counts of tlast handshakes per output.
module dma_top_sim
  import dma_top_sim_pkg::*;
#(
  parameter int C_DATA_WIDTH      = 512,
  parameter int KEEP_WIDTH        = C_DATA_WIDTH / 32,
  parameter int C_USER_WIDTH      = 128,
  parameter int FIFO_DEPTH        = 16,
  parameter int RESET_HOLD_CYCLES = 16
) (
  input  logic          sys_clk,
  input  logic          sys_reset,
  dma_top_sim_if.slave  s_axis_dma,
  dma_top_sim_if.master m_axis_qsfp0,
  dma_top_sim_if.slave  s_axis_qsfp0,
  dma_top_sim_if.master m_axis_dma,
`ifdef DMA_TOP_SIM_PKT_COUNTERS_EN
  output logic [31:0]   pkt_cnt_to_qsfp0,
  output logic [31:0]   pkt_cnt_to_dma,
`endif
  output logic          init_done
);
  localparam int BEAT_W = C_DATA_WIDTH + KEEP_WIDTH + C_USER_WIDTH + 1;
  localparam int HW     = $clog2(RESET_HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(RESET_HOLD_CYCLES);

  // ---------------------------------------------------------------- hold
  // Counts cycles out of reset and parks at HOLD_MAX, so init_done latches.
  logic [HW-1:0] hold_q, hold_d;

  always_comb begin
    hold_d = hold_q;
    if (hold_q != HOLD_MAX) hold_d = hold_q + HW'(1);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_reset) hold_q <= '0;
    else           hold_q <= hold_d;
  end

  assign init_done = (hold_q == HOLD_MAX);

  // ------------------------------------------------------- tuser rewrite
  // Only the port bytes change; len and the upper bits ride through.
  logic [C_USER_WIDTH-1:0] to_qsfp_user, to_dma_user;

  always_comb begin
    to_qsfp_user                = s_axis_dma.tuser;
    to_qsfp_user[SRC_LSB +: 8]  = PORT_DMA0;
    to_qsfp_user[DST_LSB +: 8]  = PORT_NF0;
    to_dma_user                 = s_axis_qsfp0.tuser;
    to_dma_user[SRC_LSB +: 8]   = PORT_NF0;
    to_dma_user[DST_LSB +: 8]   = PORT_DMA0;
  end

  // ------------------------------------------------------ direction FIFOs
  logic [BEAT_W-1:0] q_wr, q_rd, d_wr, d_rd;

  assign q_wr = {s_axis_dma.tdata, s_axis_dma.tkeep, to_qsfp_user, s_axis_dma.tlast};
  assign d_wr = {s_axis_qsfp0.tdata, s_axis_qsfp0.tkeep, to_dma_user, s_axis_qsfp0.tlast};

  axis_sync_fifo #(.WIDTH(BEAT_W), .DEPTH(FIFO_DEPTH)) u_fifo_to_qsfp0 (
    .clk_i      (sys_clk),
    .rst_i      (sys_reset),
    .en_i       (init_done),
    .wr_data_i  (q_wr),
    .wr_valid_i (s_axis_dma.tvalid),
    .wr_ready_o (s_axis_dma.tready),
    .rd_data_o  (q_rd),
    .rd_valid_o (m_axis_qsfp0.tvalid),
    .rd_ready_i (m_axis_qsfp0.tready)
  );

  axis_sync_fifo #(.WIDTH(BEAT_W), .DEPTH(FIFO_DEPTH)) u_fifo_to_dma (
    .clk_i      (sys_clk),
    .rst_i      (sys_reset),
    .en_i       (init_done),
    .wr_data_i  (d_wr),
    .wr_valid_i (s_axis_qsfp0.tvalid),
    .wr_ready_o (s_axis_qsfp0.tready),
    .rd_data_o  (d_rd),
    .rd_valid_o (m_axis_dma.tvalid),
    .rd_ready_i (m_axis_dma.tready)
  );

  assign {m_axis_qsfp0.tdata, m_axis_qsfp0.tkeep, m_axis_qsfp0.tuser, m_axis_qsfp0.tlast} = q_rd;
  assign {m_axis_dma.tdata,   m_axis_dma.tkeep,   m_axis_dma.tuser,   m_axis_dma.tlast}   = d_rd;

`ifdef DMA_TOP_SIM_PKT_COUNTERS_EN
  // ------------------------------------------------------ packet counters
  // One count per end-of-packet handshake; wraps naturally at 2^32.
  logic [31:0] cnt_qsfp0_q, cnt_qsfp0_d, cnt_dma_q, cnt_dma_d;
  logic        eop_qsfp0, eop_dma;

  assign eop_qsfp0 = m_axis_qsfp0.tvalid & m_axis_qsfp0.tready & m_axis_qsfp0.tlast;
  assign eop_dma   = m_axis_dma.tvalid   & m_axis_dma.tready   & m_axis_dma.tlast;

  always_comb begin
    cnt_qsfp0_d = cnt_qsfp0_q + 32'(eop_qsfp0);
    cnt_dma_d   = cnt_dma_q   + 32'(eop_dma);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      cnt_qsfp0_q <= '0;
      cnt_dma_q   <= '0;
    end else begin
      cnt_qsfp0_q <= cnt_qsfp0_d;
      cnt_dma_q   <= cnt_dma_d;
    end
  end

  assign pkt_cnt_to_qsfp0 = cnt_qsfp0_q;
  assign pkt_cnt_to_dma   = cnt_dma_q;
`endif
endmodule

// File: tb/tb_dma_top_sim.sv
`timescale 1ns/1ps
module tb_dma_top_sim;
  import dma_top_sim_pkg::*;

  localparam int DEPTH = 16;
  localparam int HOLD  = 16;

  logic sys_clk = 1'b0;
  logic sys_reset;
  logic init_done;
  always #5 sys_clk = ~sys_clk;

  dma_top_sim_if #(.DW(DATA_W), .KW(KEEP_W), .UW(USER_W)) dma_in (), qsfp_out (), qsfp_in (), dma_out ();

  // Direction 0: host -> QSFP0, direction 1: QSFP0 -> host.
  beat_t s_beat [2];
  beat_t o_beat [2];
  logic  s_valid[2], s_rdy[2], o_valid[2], m_rdy[2];

  assign dma_in.tdata   = s_beat[0].data;
  assign dma_in.tkeep   = s_beat[0].keep;
  assign dma_in.tuser   = s_beat[0].user;
  assign dma_in.tlast   = s_beat[0].last;
  assign dma_in.tvalid  = s_valid[0];
  assign s_rdy[0]       = dma_in.tready;
  assign qsfp_in.tdata  = s_beat[1].data;
  assign qsfp_in.tkeep  = s_beat[1].keep;
  assign qsfp_in.tuser  = s_beat[1].user;
  assign qsfp_in.tlast  = s_beat[1].last;
  assign qsfp_in.tvalid = s_valid[1];
  assign s_rdy[1]       = qsfp_in.tready;

  assign o_beat[0]      = {qsfp_out.tdata, qsfp_out.tkeep, qsfp_out.tuser, qsfp_out.tlast};
  assign o_valid[0]     = qsfp_out.tvalid;
  assign qsfp_out.tready = m_rdy[0];
  assign o_beat[1]      = {dma_out.tdata, dma_out.tkeep, dma_out.tuser, dma_out.tlast};
  assign o_valid[1]     = dma_out.tvalid;
  assign dma_out.tready = m_rdy[1];

`ifdef DMA_TOP_SIM_PKT_COUNTERS_EN
  logic [31:0] pkt_cnt0, pkt_cnt1;
`endif

  dma_top_sim #(
    .C_DATA_WIDTH(DATA_W), .KEEP_WIDTH(KEEP_W), .C_USER_WIDTH(USER_W),
    .FIFO_DEPTH(DEPTH), .RESET_HOLD_CYCLES(HOLD)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_reset    (sys_reset),
    .s_axis_dma   (dma_in),
    .m_axis_qsfp0 (qsfp_out),
    .s_axis_qsfp0 (qsfp_in),
    .m_axis_dma   (dma_out),
`ifdef DMA_TOP_SIM_PKT_COUNTERS_EN
    .pkt_cnt_to_qsfp0 (pkt_cnt0),
    .pkt_cnt_to_dma   (pkt_cnt1),
`endif
    .init_done    (init_done)
  );

  // ------------------------------------------------------- reference model
  beat_t        mq [2][$];   // beats the DUT owes each output, in order
  beat_t        src[2][$];   // beats still to be offered on each input
  int           hold;
  int           checks, failures;
  logic         stall[2], hs_in[2], vld_hold[2];
  beat_t        prev_beat[2];
  int           rdy_pct[2], gap_pct[2];
  int           in_beats[2], out_beats[2], out_lasts[2];
  logic [31:0]  mcnt[2];
  logic [127:0] last_user[2];

  typedef struct {
    int           dir;
    logic [127:0] uin;
    logic [127:0] uexp;
  } vec_t;
  vec_t vt[4];

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Host->wire beats are from DMA0 to NF0; wire->host the other way round.
  function automatic beat_t expect_out(input int d, input beat_t b);
    beat_t e = b;
    e.user[23:16] = (d == 0) ? 8'h02 : 8'h01;
    e.user[31:24] = (d == 0) ? 8'h01 : 8'h02;
    return e;
  endfunction

  // Called at a negedge with inputs stable: check outputs, advance model
  // by the coming posedge, then move to the next negedge.
  task automatic tick();
    logic ei, er;
    ei = (hold >= HOLD);
    chk("init_done", 512'(init_done), 512'(ei));
`ifdef DMA_TOP_SIM_PKT_COUNTERS_EN
    chk("pkt_cnt_to_qsfp0", 512'(pkt_cnt0), 512'(mcnt[0]));
    chk("pkt_cnt_to_dma", 512'(pkt_cnt1), 512'(mcnt[1]));
`endif
    for (int d = 0; d < 2; d++) begin
      hs_in[d] = 1'b0;
      er = ei && (mq[d].size() < DEPTH);
      chk($sformatf("s_tready%0d", d), 512'(s_rdy[d]), 512'(er));
      if (stall[d]) begin
        chk($sformatf("hold_tvalid%0d", d), 512'(o_valid[d]), 512'(1'b1));
        chk($sformatf("hold_tdata%0d", d), o_beat[d].data, prev_beat[d].data);
      end
      if (mq[d].size() == 0) begin
        chk($sformatf("empty_tvalid%0d", d), 512'(o_valid[d]), 512'(1'b0));
      end else if (o_valid[d]) begin
        chk($sformatf("out_tdata%0d", d), o_beat[d].data, mq[d][0].data);
        chk($sformatf("out_side%0d", d), 512'({o_beat[d].keep, o_beat[d].user, o_beat[d].last}),
            512'({mq[d][0].keep, mq[d][0].user, mq[d][0].last}));
        if (m_rdy[d]) begin
          if (mq[d][0].last) mcnt[d]++;
          void'(mq[d].pop_front());
          out_beats[d]++;
          if (o_beat[d].last) out_lasts[d]++;
          last_user[d] = o_beat[d].user;
        end
      end
      if (s_valid[d] && s_rdy[d]) begin
        hs_in[d] = 1'b1;
        in_beats[d]++;
        mq[d].push_back(expect_out(d, s_beat[d]));
      end
      stall[d]     = o_valid[d] && !m_rdy[d];
      prev_beat[d] = o_beat[d];
    end
    if (sys_reset) begin
      hold = 0;
      for (int d = 0; d < 2; d++) begin
        mq[d].delete();
        stall[d] = 1'b0;
        mcnt[d]  = '0;
      end
    end else if (hold < HOLD) begin
      hold++;
    end
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  task automatic cycle();
    for (int d = 0; d < 2; d++) begin
      m_rdy[d] = ($urandom_range(99) < rdy_pct[d]);
      if (src[d].size() != 0 && (vld_hold[d] || $urandom_range(99) >= gap_pct[d])) begin
        s_valid[d] = 1'b1;
        s_beat[d]  = src[d][0];
      end else begin
        s_valid[d] = 1'b0;
        s_beat[d]  = '0;
      end
    end
    tick();
    for (int d = 0; d < 2; d++) begin
      if (hs_in[d]) void'(src[d].pop_front());
      vld_hold[d] = s_valid[d] && !hs_in[d];
    end
  endtask

  task automatic add_pkt(input int d, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      for (int w = 0; w < 16; w++) b.data[w*32 +: 32] = $urandom;
      b.keep = 16'($urandom);
      for (int w = 0; w < 4; w++) b.user[w*32 +: 32] = $urandom;
      b.last = (i == len - 1);
      src[d].push_back(b);
    end
  endtask

  task automatic run_idle(input string tag, input int max);
    int n = 0;
    while ((src[0].size() + src[1].size() + mq[0].size() + mq[1].size()) != 0 && n < max) begin
      cycle();
      n++;
    end
    chk({tag, "_drain"}, 512'(n < max), 512'(1'b1));
  endtask

  task automatic reset_seq();
    sys_reset = 1'b1;
    repeat (3) cycle();
    sys_reset = 1'b0;
    repeat (HOLD) cycle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t       b;
    logic [511:0] a5;
    int          l0, b0, i0;

    vt[0] = '{0, 128'h0, 128'h0000_0000_0000_0000_0000_0000_0102_0000};
    vt[1] = '{0, 128'hDEAD_BEEF_CAFE_F00D_1234_5678_AAAA_0040, 128'hDEAD_BEEF_CAFE_F00D_1234_5678_0102_0040};
    vt[2] = '{1, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_0201_FFFF};
    vt[3] = '{1, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 128'h0123_4567_89AB_CDEF_0011_2233_0201_6677};

    checks = 0; failures = 0; hold = 0;
    sys_reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      s_valid[d] = 1'b0; s_beat[d] = '0; m_rdy[d] = 1'b1;
      stall[d] = 1'b0; hs_in[d] = 1'b0; vld_hold[d] = 1'b0; prev_beat[d] = '0;
      rdy_pct[d] = 100; gap_pct[d] = 0; mcnt[d] = '0;
      in_beats[d] = 0; out_beats[d] = 0; out_lasts[d] = 0; last_user[d] = '0;
    end
    @(negedge sys_clk);

    // 1: reset and hold window
    repeat (20) cycle();
    sys_reset = 1'b0;
    for (int i = 0; i < HOLD; i++) begin
      chk("hold_init_done", 512'(init_done), 512'(1'b0));
      chk("hold_tready", 512'({s_rdy[0], s_rdy[1]}), 512'(2'b00));
      cycle();
    end
    chk("post_hold_init_done", 512'(init_done), 512'(1'b1));
    chk("post_hold_tready", 512'({s_rdy[0], s_rdy[1]}), 512'(2'b11));

    // 2: single beat host -> QSFP0, visible the cycle after acceptance
    a5 = {64{8'hA5}};
    b.data = a5; b.keep = 16'hFFFF; b.user = 128'd64; b.last = 1'b1;
    src[0].push_back(b);
    cycle();
    chk("single_tvalid", 512'(o_valid[0]), 512'(1'b1));
    chk("single_tdata", o_beat[0].data, a5);
    chk("single_tuser", 512'(o_beat[0].user[31:0]), 512'(32'h0102_0040));
    chk("single_tlast", 512'(o_beat[0].last), 512'(1'b1));
    run_idle("single", 50);

    // tuser rewrite table
    for (int i = 0; i < 4; i++) begin
      for (int w = 0; w < 16; w++) b.data[w*32 +: 32] = $urandom;
      b.keep = 16'($urandom); b.user = vt[i].uin; b.last = 1'b1;
      src[vt[i].dir].push_back(b);
      run_idle($sformatf("vec%0d", i), 50);
      chk($sformatf("vec%0d_user", i), 512'(last_user[vt[i].dir]), 512'(vt[i].uexp));
    end

    // 3: 4-beat QSFP0 -> host with a 50% sink
    l0 = out_lasts[1]; b0 = out_beats[1];
    rdy_pct[1] = 50;
    add_pkt(1, 4);
    run_idle("pkt4", 200);
    chk("pkt4_beats", 512'(out_beats[1] - b0), 512'(4));
    chk("pkt4_lasts", 512'(out_lasts[1] - l0), 512'(1));
    rdy_pct[1] = 100;

    // 4: fill host -> QSFP0 against a stalled sink, then drain
    rdy_pct[0] = 0;
    i0 = in_beats[0]; b0 = out_beats[0];
    add_pkt(0, 16);
    add_pkt(0, 1);
    repeat (24) cycle();
    chk("full_accepted", 512'(in_beats[0] - i0), 512'(16));
    chk("full_tready", 512'(s_rdy[0]), 512'(1'b0));
    rdy_pct[0] = 100;
    run_idle("full", 100);
    chk("drain_beats", 512'(out_beats[0] - b0), 512'(17));
    chk("drain_tready", 512'(s_rdy[0]), 512'(1'b1));

    // 5: 100 packets each way at full rate, counters from a fresh reset
    reset_seq();
    l0 = out_lasts[0]; b0 = out_lasts[1];
    for (int p = 0; p < 100; p++) begin
      add_pkt(0, int'($urandom_range(4, 1)));
      add_pkt(1, int'($urandom_range(4, 1)));
    end
    run_idle("bulk", 2000);
    chk("bulk_pkts0", 512'(out_lasts[0] - l0), 512'(100));
    chk("bulk_pkts1", 512'(out_lasts[1] - b0), 512'(100));
`ifdef DMA_TOP_SIM_PKT_COUNTERS_EN
    chk("bulk_cnt_qsfp0", 512'(pkt_cnt0), 512'(32'd100));
    chk("bulk_cnt_dma", 512'(pkt_cnt1), 512'(32'd100));
`endif

    // random gaps and back-pressure on both sides
    rdy_pct[0] = 60; rdy_pct[1] = 80; gap_pct[0] = 30; gap_pct[1] = 30;
    for (int p = 0; p < 30; p++) begin
      add_pkt(0, int'($urandom_range(6, 1)));
      add_pkt(1, int'($urandom_range(6, 1)));
    end
    run_idle("random", 3000);
    rdy_pct[0] = 100; rdy_pct[1] = 100; gap_pct[0] = 0; gap_pct[1] = 0;

    // 6: reset in the middle of a packet
    rdy_pct[0] = 0;
    i0 = in_beats[0];
    add_pkt(0, 4);
    repeat (2) cycle();
    chk("midrst_accepted", 512'(in_beats[0] - i0), 512'(2));
    sys_reset = 1'b1;
    src[0].delete();
    vld_hold[0] = 1'b0;
    cycle();
    chk("midrst_tvalid", 512'({o_valid[0], o_valid[1]}), 512'(2'b00));
    chk("midrst_init_done", 512'(init_done), 512'(1'b0));
    chk("midrst_tready", 512'({s_rdy[0], s_rdy[1]}), 512'(2'b00));
    repeat (2) cycle();
    sys_reset = 1'b0;
    repeat (HOLD) cycle();
    rdy_pct[0] = 100;
    l0 = out_lasts[0]; b0 = out_beats[0];
    add_pkt(0, 3);
    run_idle("fresh", 100);
    chk("fresh_beats", 512'(out_beats[0] - b0), 512'(3));
    chk("fresh_lasts", 512'(out_lasts[0] - l0), 512'(1));
    repeat (4) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
